pc_stack_unit: RTL and testbench

Parametrised program-counter successor for the PIC-class core: it replaces the plain increment-only PC with a sequencer that supports increment, skip, absolute jump, computed jump, and call/return through a circular hardware return stack. It also flags the instruction being fetched after a control transfer as one to discard. It sits between the instruction decoder, which supplies `op` and `target`, and `flash_program_memory`, which consumes `pc`. It advances once per instruction cycle, when `en` is high; `en` is normally driven from the clock divisor's phase-3 output.

---
 rtl/pc_stack_unit.sv | 117 +++++++++++
 tb/tb_pc_stack_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// Program-counter sequencer with skip/jump/call/return, a circular return stack
// and a one-slot annul flag for the instruction fetched after a control transfer.
module pc_stack_unit #(
    parameter int                    PC_WIDTH     = 13,
    parameter int                    STACK_DEPTH  = 8,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
    localparam int                   DW           = $clog2(STACK_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [2:0]          op,
    input  logic [PC_WIDTH-1:0] target,
    input  logic                clear_flags,
    output logic [PC_WIDTH-1:0] pc,
    output logic                flush,
    output logic [PC_WIDTH-1:0] top,
    output logic [DW-1:0]       depth,
    output logic                overflow,
    output logic                underflow
);

    localparam int SW = $clog2(STACK_DEPTH);

    typedef enum logic [2:0] {
        OP_INC    = 3'd0,
        OP_SKIP   = 3'd1,
        OP_GOTO   = 3'd2,
        OP_CALL   = 3'd3,
        OP_RETURN = 3'd4,
        OP_LOADPC = 3'd5
    } op_e;

    logic [PC_WIDTH-1:0] stack [STACK_DEPTH];
    logic [SW-1:0]       sp;
    logic [SW-1:0]       sp_top;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] pc_next;
    logic                flush_next;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;

    // sp wraps naturally because STACK_DEPTH is a power of two
    assign sp_top = sp - SW'(1);
    assign top    = stack[sp_top];
    assign pc_inc = pc + PC_WIDTH'(1);
    assign full   = (depth == DW'(STACK_DEPTH));
    assign empty  = (depth == '0);

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        pc_next    = pc_inc;
        flush_next = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        if (!flush) begin
            unique case (op)
                OP_SKIP: flush_next = 1'b1;
                OP_GOTO, OP_LOADPC: begin
                    pc_next    = target;
                    flush_next = 1'b1;
                end
                OP_CALL: begin
                    pc_next    = target;
                    flush_next = 1'b1;
                    push       = 1'b1;
                end
                OP_RETURN: begin
                    pc_next    = stack[sp_top];
                    flush_next = 1'b1;
                    pop        = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every register in
    // the design samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_VECTOR;
            flush     <= 1'b0;
            sp        <= '0;
            depth     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (en) begin
            pc    <= pc_next;
            flush <= flush_next;
            if (push) begin
                sp <= sp + SW'(1);
                if (!full) depth <= depth + DW'(1);
            end else if (pop) begin
                sp <= sp_top;
                if (!empty) depth <= depth - DW'(1);
            end
            // a set event on the same edge beats clear_flags
            overflow  <= (push && full)  || (overflow  && !clear_flags);
            underflow <= (pop  && empty) || (underflow && !clear_flags);
        end
    end

    // NOTE: the return stack is deliberately reset so that top reads 0 after
    // reset; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
        end else if (en && push) begin
            stack[sp] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: a vector table for the basic flow plus
// hand-written sequences for stack wrap, flags, PC wrap and async reset.
module tb_pc_stack_unit;

    localparam logic [2:0] INC = 3'd0, SKIP = 3'd1, GOTO = 3'd2, CALL = 3'd3,
                           RET = 3'd4, LDPC = 3'd5;

    logic        clk;
    logic        reset;
    logic        en;
    logic [2:0]  op;
    logic [12:0] target;
    logic        clear_flags;
    logic [12:0] pc;
    logic        flush;
    logic [12:0] top;
    logic [3:0]  depth;
    logic        overflow;
    logic        underflow;

    int n_vec = 0;
    int n_mis = 0;

    pc_stack_unit dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .op          (op),
        .target      (target),
        .clear_flags (clear_flags),
        .pc          (pc),
        .flush       (flush),
        .top         (top),
        .depth       (depth),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [2:0]  op;
        logic [12:0] target;
        logic        clr;
        logic [12:0] pc;
        logic        flush;
        logic [12:0] top;
        logic [3:0]  depth;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_state(input string name, input logic [12:0] epc, input logic ef,
                                input logic [12:0] etop, input logic [3:0] ed,
                                input logic eo, input logic eu);
        check({name, ".pc"},        32'(pc),        32'(epc));
        check({name, ".flush"},     32'(flush),     32'(ef));
        check({name, ".top"},       32'(top),       32'(etop));
        check({name, ".depth"},     32'(depth),     32'(ed));
        check({name, ".overflow"},  32'(overflow),  32'(eo));
        check({name, ".underflow"}, 32'(underflow), 32'(eu));
    endtask

    // inputs change 1 time unit after a rising edge; outputs are sampled there too
    task automatic step(input logic e, input logic [2:0] o, input logic [12:0] t, input logic c);
        en = e; op = o; target = t; clear_flags = c;
        @(posedge clk);
        #1;
    endtask

    // return address pushed by the k-th call of the overflow sequence
    function automatic logic [12:0] ret_addr(input int k);
        return (k == 1) ? 13'h202 : 13'(13'h300 + 16 * (k - 1) + 2);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //            en op    target   clr  pc       fl top      dp ov un
        vecs[0]  = '{1, INC,  13'h000, 0, 13'h001, 0, 13'h000, 0, 0, 0};
        vecs[1]  = '{1, INC,  13'h000, 0, 13'h002, 0, 13'h000, 0, 0, 0};
        vecs[2]  = '{1, INC,  13'h000, 0, 13'h003, 0, 13'h000, 0, 0, 0};
        vecs[3]  = '{1, INC,  13'h000, 0, 13'h004, 0, 13'h000, 0, 0, 0};
        vecs[4]  = '{1, GOTO, 13'h00F, 0, 13'h00F, 1, 13'h000, 0, 0, 0};
        vecs[5]  = '{1, INC,  13'h000, 0, 13'h010, 0, 13'h000, 0, 0, 0};
        vecs[6]  = '{1, CALL, 13'h100, 0, 13'h100, 1, 13'h011, 1, 0, 0};
        vecs[7]  = '{1, INC,  13'h000, 0, 13'h101, 0, 13'h011, 1, 0, 0};
        vecs[8]  = '{1, RET,  13'h000, 0, 13'h011, 1, 13'h000, 0, 0, 0};
        vecs[9]  = '{1, INC,  13'h000, 0, 13'h012, 0, 13'h000, 0, 0, 0};
        vecs[10] = '{0, GOTO, 13'h1234, 1, 13'h012, 0, 13'h000, 0, 0, 0};
        vecs[11] = '{1, 3'd6, 13'h000, 0, 13'h013, 0, 13'h000, 0, 0, 0};
        vecs[12] = '{1, 3'd7, 13'h000, 0, 13'h014, 0, 13'h000, 0, 0, 0};
        vecs[13] = '{1, LDPC, 13'h200, 0, 13'h200, 1, 13'h000, 0, 0, 0};
        vecs[14] = '{1, CALL, 13'h555, 0, 13'h201, 0, 13'h000, 0, 0, 0};

        reset = 1'b1; en = 1'b0; op = INC; target = '0; clear_flags = 1'b0;
        #12;
        expect_state("reset", 13'h000, 0, 13'h000, 0, 0, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].en, vecs[i].op, vecs[i].target, vecs[i].clr);
            expect_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].flush,
                         vecs[i].top, vecs[i].depth, vecs[i].ovf, vecs[i].unf);
        end

        // nine calls into an eight-deep stack: the first entry is overwritten
        for (int k = 1; k <= 9; k++) begin
            logic [12:0] t;
            t = 13'(13'h300 + 16 * k);
            step(1, CALL, t, 0);
            expect_state($sformatf("call%0d", k), t, 1, ret_addr(k),
                         4'((k > 8) ? 8 : k), k == 9, 0);
            step(1, INC, 0, 0);
            check($sformatf("call%0d_annul.pc", k), 32'(pc), 32'(t + 13'd1));
        end

        // eight returns yield the 9th..2nd return addresses
        for (int j = 1; j <= 8; j++) begin
            step(1, RET, 0, 0);
            expect_state($sformatf("ret%0d", j), ret_addr(10 - j), 1,
                         (j == 8) ? ret_addr(9) : ret_addr(9 - j), 4'(8 - j), 1, 0);
            step(1, INC, 0, 0);
            check($sformatf("ret%0d_annul.flush", j), 32'(flush), 32'd0);
        end

        // pop from an empty stack returns the stale entry and sets underflow
        step(1, RET, 0, 0);
        expect_state("underflow", ret_addr(9), 1, ret_addr(8), 0, 1, 1);
        step(1, INC, 0, 0);
        step(1, INC, 0, 1);
        expect_state("clear_flags", 13'h384, 0, ret_addr(8), 0, 0, 0);

        // refill, then a push at full on the same edge as clear_flags
        for (int k = 0; k < 8; k++) begin
            step(1, CALL, 13'h400, 0);
            step(1, INC, 0, 0);
        end
        check("refill.depth", 32'(depth), 32'd8);
        check("refill.overflow", 32'(overflow), 32'd0);
        step(1, CALL, 13'h400, 1);
        expect_state("ovf_vs_clear", 13'h400, 1, 13'h402, 8, 1, 0);
        step(1, INC, 0, 0);

        // SKIP wraps the PC and the following GOTO lands in the annulled slot
        step(1, GOTO, 13'h1FFE, 0);
        step(1, INC, 0, 0);
        check("pre_skip.pc", 32'(pc), 32'h1FFF);
        step(1, SKIP, 0, 0);
        expect_state("skip_wrap", 13'h000, 1, 13'h402, 8, 1, 0);
        step(1, GOTO, 13'h0AAA, 0);
        expect_state("skip_annul", 13'h001, 0, 13'h402, 8, 1, 0);

        // asynchronous reset between edges right after a call
        step(1, CALL, 13'h050, 0);
        expect_state("pre_reset_call", 13'h050, 1, 13'h002, 8, 1, 0);
        #3 reset = 1'b1;
        #1;
        expect_state("async_reset", 13'h000, 0, 13'h000, 0, 0, 0);
        #1 reset = 1'b0;
        step(1, INC, 0, 0);
        expect_state("post_reset", 13'h001, 0, 13'h000, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
